// File: rtl/v_pkg.sv
// Shared types and constants for the v_mem_wr_ctrl memory write controller.
package v_pkg;

  // Controller phases: pulse the init engine, wait for it, then arbitrate.
  typedef enum logic [1:0] {
    ST_KICK = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Width of the stall-cycle statistics counter.
  localparam int STALL_W = 32;

endpackage

// File: rtl/v_init.sv
// v_init: sweeps a memory of N words, writing zero to addresses 0..N-1 in
// ascending order, one per cycle, after a single-cycle i_init pulse.
module v_init #(
  parameter int N = 64,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_init,
  output logic                 o_busy,
  output logic                 o_wen,
  output logic [$clog2(N)-1:0] o_waddr,
  output logic [W-1:0]         o_wdata
);

  localparam int AW = $clog2(N);

  logic          busy_q, busy_d;
  logic [AW-1:0] addr_q, addr_d;

  // Start (or restart) the sweep on i_init; stop after the last address.
  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    if (i_init) begin
      busy_d = 1'b1;
      addr_d = '0;
    end else if (busy_q) begin
      addr_d = addr_q + AW'(1);
      if (addr_q == AW'(N - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Sweep state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      addr_q <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_wen   = busy_q;
  assign o_waddr = addr_q;
  assign o_wdata = '0;

endmodule

// File: rtl/v_mem_wr_ctrl.sv
// v_mem_wr_ctrl: initialises a memory through v_init, then arbitrates R
// write requesters round-robin onto a single registered write port.
// Optional build macro: V_MEM_WR_CTRL_STATS_EN enables the stall counter.
//
// Handshake: requester k transfers when i_req_vld[k] & o_req_rdy[k] in the
// same cycle; o_req_rdy is combinational and at most one-hot, and a requester
// keeps vld/addr/data stable until it sees its ready.
module v_mem_wr_ctrl
  import v_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 32,
  parameter int R = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_init,
  input  logic [R-1:0]           i_req_vld,
  input  logic [R*$clog2(N)-1:0] i_req_addr,
  input  logic [R*W-1:0]         i_req_data,
  output logic [R-1:0]           o_req_rdy,
  output logic                   o_wen_r,
  output logic [$clog2(N)-1:0]   o_waddr_r,
  output logic [W-1:0]           o_wdata_r,
  output logic                   o_busy_r,
  output logic                   o_init_done_r,
  output logic [STALL_W-1:0]     o_stall_cnt_r
);

  localparam int AW = $clog2(N);
  localparam int PW = (R > 1) ? $clog2(R) : 1;

  state_e        state_q, state_d;
  logic          seen_busy_q, seen_busy_d;
  logic [PW-1:0] rr_q, rr_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          init_kick;
  logic          init_busy;
  logic          init_wen;
  logic [AW-1:0] init_waddr;
  logic [W-1:0]  init_wdata;

  logic [R-1:0]  grant;
  logic [PW-1:0] gnt_sel;
  logic          found;
  logic          hs;
  int            idx;

  logic [AW-1:0] req_addr [R];
  logic [W-1:0]  req_data [R];

  for (genvar g = 0; g < R; g++) begin : g_unpack
    assign req_addr[g] = i_req_addr[g*AW +: AW];
    assign req_data[g] = i_req_data[g*W +: W];
  end

  v_init #(
    .N(N),
    .W(W)
  ) u_init (
    .clk    (clk),
    .rst    (rst),
    .i_init (init_kick),
    .o_busy (init_busy),
    .o_wen  (init_wen),
    .o_waddr(init_waddr),
    .o_wdata(init_wdata)
  );

  // Round-robin grant: first valid requester at or after rr_q, only in RUN
  // and never in the cycle a re-initialisation is requested.
  always_comb begin
    grant   = '0;
    gnt_sel = '0;
    found   = 1'b0;
    idx     = 0;
    if (state_q == ST_RUN && !i_init) begin
      for (int i = 0; i < R; i++) begin
        idx = int'(rr_q) + i;
        if (idx >= R) idx = idx - R;
        if (!found && i_req_vld[PW'(idx)]) begin
          found            = 1'b1;
          grant[PW'(idx)]  = 1'b1;
          gnt_sel          = PW'(idx);
        end
      end
    end
  end

  assign o_req_rdy = grant;
  assign hs        = |(i_req_vld & grant);

  // Next-state and write-port selection: mirror the init engine in INIT,
  // the granted requester in RUN.
  always_comb begin
    state_d     = state_q;
    seen_busy_d = seen_busy_q;
    init_kick   = 1'b0;
    rr_d        = rr_q;
    wen_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    case (state_q)
      ST_KICK: begin
        init_kick   = 1'b1;
        seen_busy_d = 1'b0;
        state_d     = ST_INIT;
      end
      ST_INIT: begin
        wen_d = init_wen;
        if (init_wen) begin
          waddr_d = init_waddr;
          wdata_d = init_wdata;
        end
        if (init_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_init) begin
          state_d = ST_KICK;
        end else if (hs) begin
          wen_d   = 1'b1;
          waddr_d = req_addr[gnt_sel];
          wdata_d = req_data[gnt_sel];
          rr_d    = (gnt_sel == PW'(R - 1)) ? '0 : gnt_sel + PW'(1);
        end
      end
      default: state_d = ST_KICK;
    endcase
    busy_d = (state_d != ST_RUN);
    done_d = (state_d == ST_RUN);
  end

  // Controller state and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_KICK;
      seen_busy_q <= 1'b0;
      rr_q        <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_busy_q <= seen_busy_d;
      rr_q        <= rr_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_wen_r       = wen_q;
  assign o_waddr_r     = waddr_q;
  assign o_wdata_r     = wdata_q;
  assign o_busy_r      = busy_q;
  assign o_init_done_r = done_q;

`ifdef V_MEM_WR_CTRL_STATS_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Count cycles where someone wants to write but nothing transfers.
  always_comb begin
    stall_d = stall_q;
    if ((|i_req_vld) && !hs && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cnt_r = stall_q;
`else
  assign o_stall_cnt_r = '0;
`endif

endmodule

// File: tb/tb_v_mem_wr_ctrl.sv
// Bench for v_mem_wr_ctrl (N=16, W=32, R=3). Honours V_MEM_WR_CTRL_STATS_EN.
module tb_v_mem_wr_ctrl;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int R  = 3;
  localparam int AW = $clog2(N);

  logic              clk;
  logic              rst;
  logic              i_init;
  logic [R-1:0]      i_req_vld;
  logic [R*AW-1:0]   i_req_addr;
  logic [R*W-1:0]    i_req_data;
  logic [R-1:0]      o_req_rdy;
  logic              o_wen_r;
  logic [AW-1:0]     o_waddr_r;
  logic [W-1:0]      o_wdata_r;
  logic              o_busy_r;
  logic              o_init_done_r;
  logic [31:0]       o_stall_cnt_r;

  logic [AW-1:0]     req_addr [R];
  logic [W-1:0]      req_data [R];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  v_mem_wr_ctrl #(.N(N), .W(W), .R(R)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_init       (i_init),
    .i_req_vld    (i_req_vld),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .o_req_rdy    (o_req_rdy),
    .o_wen_r      (o_wen_r),
    .o_waddr_r    (o_waddr_r),
    .o_wdata_r    (o_wdata_r),
    .o_busy_r     (o_busy_r),
    .o_init_done_r(o_init_done_r),
    .o_stall_cnt_r(o_stall_cnt_r)
  );

  // Clock and packing of per-requester payloads.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < R; i++) begin
      i_req_addr[i*AW +: AW] = req_addr[i];
      i_req_data[i*W +: W]   = req_data[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: position in the init timeline (-1 = serving requests).
  int            m_seq = 0;
  int            m_rr  = 0;
  logic          exp_wen   = 1'b0;
  logic [AW-1:0] exp_waddr = '0;
  logic [W-1:0]  exp_wdata = '0;
  logic          exp_busy  = 1'b0;
  logic          exp_done  = 1'b0;
  logic [31:0]   exp_stall = '0;

  function automatic logic [R-1:0] model_grant(input logic [R-1:0] vld, input int ptr);
    logic [R-1:0] g;
    bit hit;
    g   = '0;
    hit = 1'b0;
    for (int i = 0; i < R; i++) begin
      int j;
      j = (ptr + i) % R;
      if (!hit && vld[j]) begin
        g[j] = 1'b1;
        hit  = 1'b1;
      end
    end
    return g;
  endfunction

  // Compare every cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [R-1:0] exp_rdy;
      bit hs;
      exp_rdy = (m_seq < 0 && !i_init) ? model_grant(i_req_vld, m_rr) : '0;
      check("model_rdy", 64'(o_req_rdy), 64'(exp_rdy));
      check("model_wen", 64'(o_wen_r), 64'(exp_wen));
      check("model_waddr", 64'(o_waddr_r), 64'(exp_waddr));
      check("model_wdata", 64'(o_wdata_r), 64'(exp_wdata));
      check("model_busy", 64'(o_busy_r), 64'(exp_busy));
      check("model_done", 64'(o_init_done_r), 64'(exp_done));
      check("model_stall", 64'(o_stall_cnt_r), 64'(exp_stall));
      if (rst) begin
        m_seq = 0; m_rr = 0;
        exp_wen = 1'b0; exp_waddr = '0; exp_wdata = '0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_stall = '0;
      end else begin
        hs = (exp_rdy != '0);
`ifdef V_MEM_WR_CTRL_STATS_EN
        if ((|i_req_vld) && !hs && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
        if (m_seq < 0) begin
          exp_wen = hs;
          for (int k = 0; k < R; k++) begin
            if (exp_rdy[k]) begin
              exp_waddr = req_addr[k];
              exp_wdata = req_data[k];
              m_rr = (k + 1) % R;
            end
          end
          if (i_init) m_seq = 0;
        end else begin
          exp_wen = (m_seq >= 1 && m_seq <= N);
          if (exp_wen) begin
            exp_waddr = AW'(m_seq - 1);
            exp_wdata = '0;
          end
          m_seq = (m_seq == N + 1) ? -1 : m_seq + 1;
        end
        exp_busy = (m_seq >= 0);
        exp_done = (m_seq < 0);
      end
    end
  end

  // Follow an init sequence to RUN, pinning the written addresses literally.
  task automatic wait_init(input string name);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (guard < 100) begin
      @(negedge clk);
      guard++;
      if (o_init_done_r) break;
      if (o_wen_r) begin
        check({name, "_addr"}, 64'(o_waddr_r), 64'(n));
        check({name, "_data"}, 64'(o_wdata_r), 64'd0);
        if (n == 0) check({name, "_busy_hi"}, 64'(o_busy_r), 64'd1);
        n++;
      end
    end
    check({name, "_timeout"}, 64'(guard < 100), 64'd1);
    check({name, "_count"}, 64'(n), 64'(N));
    check({name, "_busy_lo"}, 64'(o_busy_r), 64'd0);
  endtask

  task automatic drive_req(input logic [R-1:0] vld);
    @(posedge clk); #1;
    i_req_vld = vld;
  endtask

  initial begin
    logic [R-1:0] grants [6];
    int wen_cnt;
    int guard;
    rst = 1'b1; i_init = 1'b0; i_req_vld = '0;
    for (int i = 0; i < R; i++) begin
      req_addr[i] = AW'(i + 1);
      req_data[i] = 32'hA0 + 32'(i);
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_wen", 64'(o_wen_r), 64'd0);
    check("rst_busy", 64'(o_busy_r), 64'd0);
    check("rst_done", 64'(o_init_done_r), 64'd0);
    check("rst_stall", 64'(o_stall_cnt_r), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init("init0");

    // All three valid for six cycles: strict rotation, back-to-back writes.
    drive_req(3'b111);
    wen_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 6) grants[i] = o_req_rdy;
      if (i >= 1 && o_wen_r) wen_cnt++;
      if (i == 5) begin
        @(posedge clk); #1;
        i_req_vld = '0;
      end
    end
    check("rr_g0", 64'(grants[0]), 64'b001);
    check("rr_g1", 64'(grants[1]), 64'b010);
    check("rr_g2", 64'(grants[2]), 64'b100);
    check("rr_g3", 64'(grants[3]), 64'b001);
    check("rr_g4", 64'(grants[4]), 64'b010);
    check("rr_g5", 64'(grants[5]), 64'b100);
    check("rr_wen_cnt", 64'(wen_cnt), 64'd6);

    // Single requester 1.
    req_addr[1] = AW'(5);
    req_data[1] = 32'hDEAD_BEEF;
    drive_req(3'b010);
    @(negedge clk);
    check("single_rdy", 64'(o_req_rdy), 64'b010);
    drive_req(3'b000);
    @(negedge clk);
    check("single_wen", 64'(o_wen_r), 64'd1);
    check("single_waddr", 64'(o_waddr_r), 64'd5);
    check("single_wdata", 64'(o_wdata_r), 64'hDEAD_BEEF);

    // Re-init coincident with requester 0 valid; 0 waits through init.
    req_addr[0] = AW'(9);
    req_data[0] = 32'h1234_5678;
    @(posedge clk); #1;
    i_init = 1'b1;
    i_req_vld = 3'b001;
    @(negedge clk);
    check("reinit_rdy", 64'(o_req_rdy), 64'd0);
    @(posedge clk); #1;
    i_init = 1'b0;
    @(negedge clk);
    check("reinit_done_lo", 64'(o_init_done_r), 64'd0);
    wait_init("init1");
    check("reinit_grant0", 64'(o_req_rdy), 64'b001);
`ifdef V_MEM_WR_CTRL_STATS_EN
    check("stall_ge16", 64'(o_stall_cnt_r >= 32'd16), 64'd1);
`else
    check("stall_zero", 64'(o_stall_cnt_r), 64'd0);
`endif
    drive_req(3'b000);
    @(negedge clk);
    check("reinit_wen", 64'(o_wen_r), 64'd1);
    check("reinit_waddr", 64'(o_waddr_r), 64'd9);
    check("reinit_wdata", 64'(o_wdata_r), 64'h1234_5678);

    // Reset in the middle of an init sweep.
    @(posedge clk); #1;
    i_init = 1'b1;
    @(posedge clk); #1;
    i_init = 1'b0;
    guard = 0;
    while (guard < 40) begin
      @(negedge clk);
      guard++;
      if (o_wen_r && o_waddr_r == AW'(7)) break;
    end
    check("midrst_reach7", 64'(guard < 40), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_wen", 64'(o_wen_r), 64'd0);
    check("midrst_waddr", 64'(o_waddr_r), 64'd0);
    check("midrst_wdata", 64'(o_wdata_r), 64'd0);
    check("midrst_busy", 64'(o_busy_r), 64'd0);
    check("midrst_done", 64'(o_init_done_r), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init("init2");

    // Pointer wrap: from rr=0 grant 0, then with 0 and 2 valid pick 2, then 0.
    drive_req(3'b001);
    @(negedge clk);
    check("wrap_a", 64'(o_req_rdy), 64'b001);
    drive_req(3'b101);
    @(negedge clk);
    check("wrap_b", 64'(o_req_rdy), 64'b100);
    drive_req(3'b001);
    @(negedge clk);
    check("wrap_c", 64'(o_req_rdy), 64'b001);
    drive_req(3'b000);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
